// File: rtl/pipe_stall_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush sequencer.
//   master : datapath side; drives the hazard, branch and data-memory status.
//   slave  : sequencer side; drives per-stage enables and flushes, the sticky
//            memory-timeout error and the stall/flush performance counters.
interface pipe_stall_if #(
    parameter int CNT_W = 16
);
    logic             hazard_enable;  // 0 = load-use hazard
    logic             branch_taken;   // branch resolved taken in MEM
    logic             dmem_req;       // EX/MEM holds a load or store
    logic             dmem_ready;     // data memory completes this cycle
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output hazard_enable, branch_taken, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush,
        input  mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  hazard_enable, branch_taken, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush,
        output mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for a 5-stage pipeline.
// Merges load-use hazards, taken-branch redirects from MEM and multi-cycle
// data-memory waits into per-stage enable/flush controls. A watchdog turns a
// memory wait of MEM_TIMEOUT consecutive stalled cycles into a sticky error
// state that only reset leaves. Saturating counters track stalled cycles
// (pc_en low) and branch-flush events.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : pipe_stall_if.slave (status inputs, control/counter outputs)
// Control outputs are combinational from state and inputs; mem_err and the
// counters are registered.
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,  // >= 2
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         reset,
    pipe_stall_if.slave  bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mstall;
    logic active;     // RUN or MEM_WAIT, out of reset
    logic br_flush;   // rule-2 cycle
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush;

    assign mstall = bus.dmem_req & ~bus.dmem_ready;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        br_flush     = 1'b0;
        active       = !reset && (state_q != ST_ERROR);

        // Priority: memory freeze > branch redirect > load-use bubble > run.
        // The ready cycle of a wait falls through to the lower rules, so a
        // branch held in EX/MEM during the freeze flushes on that cycle.
        if (active && !mstall) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (bus.branch_taken) begin
                br_flush     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (!bus.hazard_enable) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (mstall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!mstall) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = ST_ERROR;
        endcase

        if (state_d == ST_ERROR) mem_err_d = 1'b1;

        if (active && !pc_en && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (br_flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.id_ex_en     = id_ex_en;
    assign bus.ex_mem_en    = ex_mem_en;
    assign bus.mem_wb_en    = mem_wb_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
endmodule
